// File: rtl/ascon_sbox_layer_seq.sv
`default_nettype none
// ============================================================================
// Module      : ascon_sbox_layer_seq
// Description : Sequential ASCON 5-bit S-box layer, LANES columns per cycle,
//               valid/ready handshake on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module ascon_sbox_layer_seq #(
  parameter int LANES   = 8,
  parameter int OUT_REG = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] x0_in,
  input  logic [63:0] x1_in,
  input  logic [63:0] x2_in,
  input  logic [63:0] x3_in,
  input  logic [63:0] x4_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] x0_out,
  output logic [63:0] x1_out,
  output logic [63:0] x2_out,
  output logic [63:0] x3_out,
  output logic [63:0] x4_out,
  output logic        busy,
  output logic [15:0] blk_cnt
);

  localparam logic [5:0] c_LAST = 6'(64 - LANES);
  localparam logic [6:0] c_STEP = 7'(LANES);

  // S_LOAD is the DONE-entry cycle that fills the output register (OUT_REG=1 only)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [63:0] r_x     [5];
  logic [63:0] w_x_sub [5];
  logic [5:0]  r_col;
  logic [15:0] r_blk_cnt;
  logic [5:0]  w_idx;
  logic [4:0]  w_sin;
  logic [4:0]  w_sout;
  logic        w_accept;
  logic        w_deliver;

  function automatic logic [4:0] sbox(input logic [4:0] v);
    case (v)
      5'h00: sbox = 5'h04;  5'h01: sbox = 5'h0B;  5'h02: sbox = 5'h1F;  5'h03: sbox = 5'h14;
      5'h04: sbox = 5'h1A;  5'h05: sbox = 5'h15;  5'h06: sbox = 5'h09;  5'h07: sbox = 5'h02;
      5'h08: sbox = 5'h1B;  5'h09: sbox = 5'h05;  5'h0A: sbox = 5'h08;  5'h0B: sbox = 5'h12;
      5'h0C: sbox = 5'h1D;  5'h0D: sbox = 5'h03;  5'h0E: sbox = 5'h06;  5'h0F: sbox = 5'h1C;
      5'h10: sbox = 5'h1E;  5'h11: sbox = 5'h13;  5'h12: sbox = 5'h07;  5'h13: sbox = 5'h0E;
      5'h14: sbox = 5'h00;  5'h15: sbox = 5'h0D;  5'h16: sbox = 5'h11;  5'h17: sbox = 5'h18;
      5'h18: sbox = 5'h10;  5'h19: sbox = 5'h0C;  5'h1A: sbox = 5'h01;  5'h1B: sbox = 5'h19;
      5'h1C: sbox = 5'h16;  5'h1D: sbox = 5'h0A;  5'h1E: sbox = 5'h0F;  default: sbox = 5'h17;
    endcase
  endfunction

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_deliver = (r_state == S_DONE) && out_ready;
  assign blk_cnt   = r_blk_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = S_BUSY;
      end
      S_BUSY: begin
        busy = 1'b1;
        if (r_col == c_LAST) w_state_nx = (OUT_REG != 0) ? S_LOAD : S_DONE;
      end
      S_LOAD: w_state_nx = S_DONE;
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Column groups are LANES-aligned, so col+j never wraps inside one cycle
  always_comb begin
    for (int k = 0; k < 5; k++) w_x_sub[k] = r_x[k];
    w_idx  = '0;
    w_sin  = '0;
    w_sout = '0;
    for (int j = 0; j < LANES; j++) begin
      w_idx  = r_col + 6'(j);
      w_sin  = {r_x[0][w_idx], r_x[1][w_idx], r_x[2][w_idx], r_x[3][w_idx], r_x[4][w_idx]};
      w_sout = sbox(w_sin);
      w_x_sub[0][w_idx] = w_sout[4];
      w_x_sub[1][w_idx] = w_sout[3];
      w_x_sub[2][w_idx] = w_sout[2];
      w_x_sub[3][w_idx] = w_sout[1];
      w_x_sub[4][w_idx] = w_sout[0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_blk_cnt <= '0;
      for (int k = 0; k < 5; k++) r_x[k] <= '0;
    end else begin
      if (w_accept) begin
        r_x[0] <= x0_in;
        r_x[1] <= x1_in;
        r_x[2] <= x2_in;
        r_x[3] <= x3_in;
        r_x[4] <= x4_in;
        r_col  <= '0;
      end else if (r_state == S_BUSY) begin
        for (int k = 0; k < 5; k++) r_x[k] <= w_x_sub[k];
        r_col <= r_col + c_STEP[5:0];
      end
      if (w_deliver) r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [63:0] r_y [5];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int k = 0; k < 5; k++) r_y[k] <= '0;
        end else if (r_state == S_LOAD) begin
          for (int k = 0; k < 5; k++) r_y[k] <= r_x[k];
        end
      end
      assign x0_out = r_y[0];
      assign x1_out = r_y[1];
      assign x2_out = r_y[2];
      assign x3_out = r_y[3];
      assign x4_out = r_y[4];
    end else begin : g_out_direct
      assign x0_out = r_x[0];
      assign x1_out = r_x[1];
      assign x2_out = r_x[2];
      assign x3_out = r_x[3];
      assign x4_out = r_x[4];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/ascon_sbox_layer_seq.md
ASCON_SBOX_LAYER_SEQ -- requirements
Module: ascon_sbox_layer_seq

Interface
REQ-001 Parameter LANES, default 8: number of 5-bit S-boxes evaluated per clock; SHALL be one of 1,2,4,8,16,32,64.
REQ-002 Parameter OUT_REG, default 1: 1 = registered result words; 0 = result words driven directly from the state register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  input block offered.
REQ-006 in_ready  output  1  block accepted when in_valid & in_ready.
REQ-007 x0_in..x4_in  input  64 each  ASCON state words of the offered block.
REQ-008 out_valid  output  1  substituted block available.
REQ-009 out_ready  input  1  consumer takes the block when out_valid & out_ready.
REQ-010 x0_out..x4_out  output  64 each  substituted state words.
REQ-011 busy  output  1  high in BUSY.
REQ-012 blk_cnt  output  16  count of blocks delivered; wraps 0xFFFF->0x0000.

Function
REQ-013 Column i (0..63) SHALL form S-box input {x0[i],x1[i],x2[i],x3[i],x4[i]}, with x0 as MSB, and write the output back to the same bit positions, x0 as MSB.
REQ-014 The S-box SHALL be S[0..31] = 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17 (hex).
REQ-015 FSM states: IDLE, BUSY, DONE; state encoding is free.
REQ-016 IDLE: in_ready=1; on in_valid, latch x0_in..x4_in, clear column counter col, go BUSY.
REQ-017 BUSY: each cycle, substitute columns col..col+LANES-1 in place; col += LANES; after the cycle that processes column 63, go DONE.
REQ-018 BUSY SHALL last exactly 64/LANES cycles; in_ready=0 in BUSY and DONE.
REQ-019 DONE: out_valid=1 and outputs hold the full substituted block; outputs SHALL stay stable while out_ready=0.
REQ-020 DONE with out_ready=1: blk_cnt += 1 (mod 2^16), go IDLE; no block SHALL be accepted in that same cycle.
REQ-021 Latency: for acceptance at edge t, out_valid SHALL rise after edge t+64/LANES (OUT_REG=0) or t+64/LANES+1 (OUT_REG=1, with one extra DONE-entry cycle).
REQ-022 Throughput: one block per 64/LANES+2 cycles (OUT_REG=0) or 64/LANES+3 (OUT_REG=1) under continuous in_valid/out_ready.
REQ-023 x*_in changes while not accepting SHALL have no effect; in_valid=0 in IDLE SHALL leave the state unchanged.
REQ-024 LANES=64: BUSY SHALL last one cycle; col SHALL be 6 bits and SHALL NOT overflow into other state.

Reset
REQ-025 rst_n=0 at an edge SHALL, in any state including mid-BUSY, force IDLE, col=0, blk_cnt=0, out_valid=0, busy=0, in_ready=1 from the next cycle, and x*_out=0.
REQ-026 An aborted block SHALL never be delivered and SHALL NOT increment blk_cnt.

Verification
REQ-027 LANES=8, all-zero input, out_ready=1 -> after 8 BUSY cycles x2_out=FFFF_FFFF_FFFF_FFFF, all other words 0, blk_cnt=1.
REQ-028 All-ones input -> x0,x2,x3,x4_out=all ones, x1_out=0.
REQ-029 x1_in=x3_in=x4_in=all ones, x0_in=x2_in=0 (column 0x0B) -> x0_out=x3_out=all ones, others 0; checks entry 0x12.
REQ-030 Random blocks for LANES in {1,8,64} and OUT_REG in {0,1}, checked against a per-column model built from REQ-014 -> all 64 columns match; busy length equals 64/LANES.
REQ-031 out_ready held low 20 cycles in DONE -> outputs stable, in_ready=0, blk_cnt unchanged; on release -> single increment.
REQ-032 rst_n low in the 3rd BUSY cycle (LANES=4) -> next cycle IDLE, out_valid=0, blk_cnt=0; the next block processes correctly.
